// File: rtl/lut_engine_pkg.sv
// Shared types for lut_engine: FSM state encoding and signature width.
package lut_engine_pkg;

  localparam int SIG_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/lut_bank.sv
// CH programmable truth tables of 2^IN_W bits each; whole-table write, combinational read.
module lut_bank #(
  parameter int IN_W  = 3,
  parameter int CH    = 2,
  parameter int CH_W  = 1,
  parameter int DEPTH = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DEPTH-1:0] wr_data,
  input  logic [IN_W-1:0]  rd_code,
  output logic [CH-1:0]    rd_data
);

  // Out-of-range channel selects match no table and are dropped here.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [DEPTH-1:0] tbl_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        tbl_q <= '0;
      else if (we && wr_ch == CH_W'(c))  tbl_q <= wr_data;
    end

    assign rd_data[c] = tbl_q[rd_code];
  end

endmodule

// File: rtl/lut_engine.sv
// Registered multi-channel LUT evaluator with a built-in exhaustive input sweep.
// Optional LUT_ENGINE_SIG_EN adds a 16-bit rotate-xor signature of sweep results.
module lut_engine
  import lut_engine_pkg::*;
#(
  parameter int IN_W = 3,
  parameter int CH   = 2,
  parameter int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [(1<<IN_W)-1:0]  cfg_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH-1:0]         out_data,
  output logic [IN_W-1:0]       out_idx,
  input  logic                  sweep_start,
  output logic                  sweep_busy,
  output logic                  sweep_done
`ifdef LUT_ENGINE_SIG_EN
  , output logic [SIG_W-1:0]    sig
`endif
);

  localparam logic [IN_W-1:0] LAST = '1;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   cnt_q, cnt_d;
  logic              out_valid_q, out_sw_q, done_q;
  logic [CH-1:0]     out_data_q, rd_data;
  logic [IN_W-1:0]   out_idx_q, rd_code;
  logic              slot_free, accept, sw_load, hs;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign sw_load   = (state_q == ST_SWEEP) && slot_free;
  assign hs        = out_valid_q && out_ready;
  assign rd_code   = sw_load ? cnt_q : in_data;

  // Tables are frozen for the whole sweep so every swept code sees one table set.
  lut_bank #(.IN_W(IN_W), .CH(CH), .CH_W(CH_W)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we && state_q == ST_IDLE),
    .wr_ch   (cfg_ch),
    .wr_data (cfg_data),
    .rd_code (rd_code),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (sweep_start) begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
      ST_SWEEP: if (slot_free) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sw_q    <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == ST_DRAIN) && hs;
      if (accept || sw_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rd_data;
        out_idx_q   <= rd_code;
        out_sw_q    <= sw_load;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_idx    = out_idx_q;
  assign sweep_busy = (state_q != ST_IDLE);
  assign sweep_done = done_q;

`ifdef LUT_ENGINE_SIG_EN
  logic [SIG_W-1:0] sig_q;

  // Only results tagged as sweep loads fold in; a plain lookup draining early in SWEEP does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    sig_q <= '0;
    else if (state_q == ST_IDLE && sweep_start)    sig_q <= '0;
    else if (hs && out_sw_q)
      sig_q <= {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(out_data_q);
  end

  assign sig = sig_q;
`endif

endmodule

// File: tb/tb_lut_engine.sv
// Self-checking bench for lut_engine: scoreboard model plus directed literal checks and random traffic.
module tb_lut_engine;

  localparam int IN_W = 3;
  localparam int CH   = 2;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [CH_W-1:0] cfg_ch = '0;
  logic [7:0]      cfg_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [CH-1:0]   out_data;
  logic [IN_W-1:0] out_idx;
  logic            sweep_start = 1'b0;
  logic            sweep_busy;
  logic            sweep_done;
`ifdef LUT_ENGINE_SIG_EN
  logic [15:0]     sig;
`endif

  always #5 clk = ~clk;

  lut_engine #(.IN_W(IN_W), .CH(CH), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done)
`ifdef LUT_ENGINE_SIG_EN
    , .sig(sig)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] idx;
    logic [1:0] data;
    logic       sw;
  } item_t;

  item_t       sb[$];
  item_t       it;
  logic [7:0]  tbl_m [2];
  bit          busy_m = 0, done_m = 0, nx_busy, nx_done;
  logic [15:0] sig_m = '0;
  bit          prev_stall = 0, exp_acc = 0;
  logic [1:0]  prev_data;
  logic [2:0]  prev_idx, acc_idx;
  logic [1:0]  log_data [8];
  logic [1:0]  exp_seq [8] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd3};

  function automatic logic [1:0] lut(input logic [2:0] code);
    return {tbl_m[1][code], tbl_m[0][code]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      tbl_m[0] = '0; tbl_m[1] = '0;
      busy_m = 0; done_m = 0; sig_m = '0; prev_stall = 0; exp_acc = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_busy", sweep_busy, 0);
      chk("rst_done", sweep_done, 0);
`ifdef LUT_ENGINE_SIG_EN
      chk("rst_sig", sig, 0);
`endif
    end else begin
      chk("busy", sweep_busy, busy_m);
      chk("done", sweep_done, done_m);
      chk("in_ready", in_ready, !busy_m && (!out_valid || out_ready));
`ifdef LUT_ENGINE_SIG_EN
      chk("sig", sig, sig_m);
`endif
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_idx", out_idx, prev_idx);
      end
      if (exp_acc) begin
        chk("lat_valid", out_valid, 1);
        chk("lat_idx", out_idx, acc_idx);
      end
      nx_busy = busy_m;
      nx_done = 0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_result", 1, 0);
        end else begin
          it = sb.pop_front();
          chk("res_idx", out_idx, it.idx);
          chk("res_data", out_data, it.data);
          log_data[it.idx] = out_data;
          if (it.sw) begin
            sig_m = {sig_m[14:0], sig_m[15]} ^ {14'b0, it.data};
            if (it.idx == 3'd7) begin nx_busy = 0; nx_done = 1; end
          end
        end
      end
      // Lookup reads old tables; a same-cycle write lands before any sweep load.
      exp_acc = in_valid && in_ready;
      acc_idx = in_data;
      if (exp_acc) sb.push_back('{idx: in_data, data: lut(in_data), sw: 1'b0});
      if (cfg_we && cfg_ch < 2 && !busy_m) tbl_m[cfg_ch[0]] = cfg_data;
      if (!busy_m && sweep_start) begin
        nx_busy = 1;
        sig_m = '0;
        for (int k = 0; k < 8; k++) sb.push_back('{idx: 3'(k), data: lut(3'(k)), sw: 1'b1});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
      busy_m = nx_busy;
      done_m = nx_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] d);
    cfg_we = 1; cfg_ch = ch; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic lookup_lit(input string nm, input logic [2:0] code, input logic [1:0] exp);
    in_valid = 1; in_data = code;
    tick();
    in_valid = 0; cfg_we = 0;
    @(negedge clk);
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_idx"}, out_idx, code);
    tick();
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (sweep_done) seen = 1;
    end
    chk({nm, "_done_seen"}, seen, 1);
    tick();
  endtask

  task automatic wait_idx(input string nm, input logic [2:0] k);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == k) seen = 1;
    end
    chk({nm, "_idx_seen"}, seen, 1);
  endtask

  task automatic clear_log();
    for (int k = 0; k < 8; k++) log_data[k] = 'x;
  endtask

  task automatic check_log(input string nm);
    for (int k = 0; k < 8; k++) chk($sformatf("%s_code%0d", nm, k), log_data[k], exp_seq[k]);
  endtask

  task automatic pulse_sweep();
    sweep_start = 1;
    tick();
    sweep_start = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();

    cfg(2'd0, 8'hE8);
    cfg(2'd1, 8'h96);
    lookup_lit("lk3", 3'd3, 2'b01);

    clear_log();
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; in_data = 3'(k);
      tick();
    end
    in_valid = 0;
    repeat (2) tick();
    check_log("stream");

    clear_log();
    pulse_sweep();
    wait_done("sweep1");
    check_log("sweep1");
`ifdef LUT_ENGINE_SIG_EN
    chk("sig_literal", sig, 16'h00C5);
`endif

    // Backpressure on idx 4, with an ignored table write during the stall.
    clear_log();
    pulse_sweep();
    wait_idx("bp", 3'd3);
    tick();
    out_ready = 0;
    cfg_we = 1; cfg_ch = 2'd0; cfg_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_idx", out_idx, 3'd4);
      chk("bp_hold_data", out_data, 2'b10);
      tick();
      cfg_we = 0;
    end
    out_ready = 1;
    wait_done("sweep_bp");
    check_log("sweep_bp");
    lookup_lit("busy_write_ignored", 3'd0, 2'b00);

    cfg(2'd3, 8'hFF);
    lookup_lit("ch3_ignored", 3'd0, 2'b00);

    cfg_we = 1; cfg_ch = 2'd1; cfg_data = 8'h00;
    lookup_lit("same_cycle_old", 3'd1, 2'b10);
    lookup_lit("same_cycle_new", 3'd1, 2'b00);
    cfg(2'd1, 8'h96);

    // Reset mid-sweep.
    pulse_sweep();
    wait_idx("rst", 3'd1);
    tick();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    lookup_lit("tables_cleared", 3'd7, 2'b00);
    cfg(2'd0, 8'hE8);
    cfg(2'd1, 8'h96);
    clear_log();
    pulse_sweep();
    wait_done("sweep_after_rst");
    check_log("sweep_after_rst");

    // Random traffic against the scoreboard.
    for (int i = 0; i < 1500; i++) begin
      in_valid    = $urandom_range(0, 1) != 0;
      in_data     = 3'($urandom);
      out_ready   = $urandom_range(0, 3) != 0;
      cfg_we      = $urandom_range(0, 7) == 0;
      cfg_ch      = 2'($urandom);
      cfg_data    = 8'($urandom);
      sweep_start = $urandom_range(0, 63) == 0;
      tick();
    end
    in_valid = 0; cfg_we = 0; sweep_start = 0; out_ready = 1;
    quiet = 0;
    for (int i = 0; i < 100 && !quiet; i++) begin
      @(negedge clk);
      if (!sweep_busy && !out_valid && !sweep_done) quiet = 1;
    end
    chk("final_quiet", quiet, 1);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
